// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA controller and its memory-side responder:
// access FSM state encoding, default bus widths, wait-counter sizing helper and
// the write-protect window check.
// No ports (package).
// -----------------------------------------------------------------------------
package dma_pkg;

   localparam int unsigned DMA_ADDR_W          = 4;
   localparam int unsigned DMA_DATA_W          = 8;
   localparam int unsigned DMA_WAIT_STATES_MAX = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } dma_state_e;

   // Number of bits needed to encode v distinct values (minimum 1).
   function automatic int unsigned ceil_log2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) begin
         r++;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

   // True when addr lies in the inclusive window lo..hi.
   // An inverted window (lo > hi) means protection is disabled.
   function automatic logic wp_hit(input logic [31:0] addr,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
      return (lo <= hi) && (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/dma_mem_array.sv
// -----------------------------------------------------------------------------
// dma_mem_array
// Register-file storage for dma_mem_responder: two write ports (front-door bus
// commit and back-door load) and one asynchronous read port. When both write
// ports hit the same word on the same edge the front-door write is kept.
// Contents are not reset.
// Ports:
//   clk        rising-edge clock
//   fd_we_i    front-door write enable; fd_addr_i / fd_data_i address and data
//   bd_we_i    back-door write enable;  bd_addr_i / bd_data_i address and data
//   rd_addr_i  read address; rd_data_o returns pre-edge contents
// -----------------------------------------------------------------------------
module dma_mem_array
   import dma_pkg::*;
#(
   parameter int unsigned ADDR_W = DMA_ADDR_W,
   parameter int unsigned DATA_W = DMA_DATA_W
) (
   input  logic              clk,
   input  logic              fd_we_i,
   input  logic [ADDR_W-1:0] fd_addr_i,
   input  logic [DATA_W-1:0] fd_data_i,
   input  logic              bd_we_i,
   input  logic [ADDR_W-1:0] bd_addr_i,
   input  logic [DATA_W-1:0] bd_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Front-door assignment is last, so it wins an address collision.
   always_ff @(posedge clk) begin
      if (bd_we_i) begin
         mem_q[bd_addr_i] <= bd_data_i;
      end
      if (fd_we_i) begin
         mem_q[fd_addr_i] <= fd_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dma_mem_responder.sv
// -----------------------------------------------------------------------------
// dma_mem_responder
// Memory-side responder on the DMA controller's active-low CE/WE bus. Accepts
// one read or write per access, inserts WAIT_STATES wait cycles, then pulses
// mem_ready for one cycle. Writes into the WP_LO..WP_HI window are refused and
// flagged with mem_err alongside mem_ready.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_ce_n, mem_we_n      request (active low), 0 = write / 1 = read
//   mem_addr, mem_data_in   access address and write data
//   mem_data_out            registered read data, held until next read ack
//   mem_ready, mem_err      one-cycle acknowledge, protected-write error
//   ld_en, ld_addr, ld_data back-door load port (any state)
//   wr_count                saturating count of committed front-door writes
// -----------------------------------------------------------------------------
module dma_mem_responder
   import dma_pkg::*;
#(
   parameter int unsigned       ADDR_W      = DMA_ADDR_W,
   parameter int unsigned       DATA_W      = DMA_DATA_W,
   parameter int unsigned       WAIT_STATES = 1,
   parameter logic [ADDR_W-1:0] WP_LO       = 4'hE,
   parameter logic [ADDR_W-1:0] WP_HI       = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_ce_n,
   input  logic              mem_we_n,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_ready,
   output logic              mem_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [7:0]        wr_count
);

   localparam int unsigned      CNT_W   = ceil_log2(DMA_WAIT_STATES_MAX + 1);
   localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

   dma_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_n_q, we_n_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] dout_q;
   logic              ready_q;
   logic              err_q;
   logic [7:0]        wr_cnt_q;

   // Commit happens on the edge that enters ACK. With zero wait states that
   // is the accept edge itself, so the bus inputs are used directly instead
   // of the latched copies.
   logic              commit;
   logic [ADDR_W-1:0] c_addr;
   logic              c_we_n;
   logic [DATA_W-1:0] c_data;
   logic              c_wp;
   logic              fd_we;
   logic [DATA_W-1:0] rd_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_n_d  = we_n_q;
      data_d  = data_q;
      commit  = 1'b0;
      c_addr  = addr_q;
      c_we_n  = we_n_q;
      c_data  = data_q;

      case (state_q)
         ST_IDLE: begin
            if (!mem_ce_n) begin
               addr_d = mem_addr;
               we_n_d = mem_we_n;
               data_d = mem_data_in;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
                  commit  = 1'b1;
                  c_addr  = mem_addr;
                  c_we_n  = mem_we_n;
                  c_data  = mem_data_in;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_ACK;
               commit  = 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign c_wp  = wp_hit(32'(c_addr), 32'(WP_LO), 32'(WP_HI));
   assign fd_we = commit && !c_we_n && !c_wp;

   dma_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk       (clk),
      .fd_we_i   (fd_we),
      .fd_addr_i (c_addr),
      .fd_data_i (c_data),
      .bd_we_i   (ld_en),
      .bd_addr_i (ld_addr),
      .bd_data_i (ld_data),
      .rd_addr_i (c_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         we_n_q   <= 1'b1;
         data_q   <= '0;
         dout_q   <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         wr_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_n_q  <= we_n_d;
         data_q  <= data_d;
         ready_q <= commit;
         err_q   <= commit && !c_we_n && c_wp;
         if (commit && c_we_n) begin
            dout_q <= rd_data;
         end
         if (fd_we && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + 8'd1;
         end
      end
   end

   assign mem_data_out = dout_q;
   assign mem_ready    = ready_q;
   assign mem_err      = err_q;
   assign wr_count     = wr_cnt_q;

endmodule
